// File: rtl/lcs_pkg.sv
// Shared definitions for the LCS request/acknowledge link: FSM states,
// address width and the temperature byte window.
package lcs_pkg;

    localparam int LCS_ADDR_W      = 9;
    localparam int TEMP_ADDR_FIRST = 184;
    localparam int TEMP_ADDR_LAST  = 187;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        REL,
        PUSH,
        NEXT
    } lcs_state_e;

    // True for LCS addresses that carry live temperature bytes.
    function automatic logic is_temp_addr(input int addr);
        return (addr >= TEMP_ADDR_FIRST) && (addr <= TEMP_ADDR_LAST);
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for signals arriving from another clock domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    // Shift the async input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronous active-low reset clears both stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/lcs_frame_reader.sv
// Initiator side of the LCS ROM link: walks addresses 0..FRAME_LEN-1, runs a
// four-phase rqRom/ack handshake per byte and streams each byte downstream.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | request raised (or held off while a stale ack is still high)
// CAPT  | sample data_in, drop the request
// REL   | wait for ack to fall
// PUSH  | byte offered on out_valid/out_ready
// NEXT  | advance address or finish the frame
module lcs_frame_reader
    import lcs_pkg::*;
#(
    parameter int FRAME_LEN = 512,
    parameter int ADDR_W    = LCS_ADDR_W,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rqRom,
    input  logic              ack,
    output logic [ADDR_W-1:0] LCSaddr,
    input  logic [7:0]        data_in,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_LEN - 1);

    lcs_state_e        state_q, state_d;
    logic              rq_q, rq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic ack_s;
    logic cnt_clr, cnt_inc;
    logic addr_clr, addr_inc;
    logic cnt_hit;
    logic last_addr;

    sync2 #(.W(1)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack),
        .q   (ack_s)
    );

    // The wait that ends on this cycle is the TIMEOUT-th one.
    assign cnt_hit   = (cnt_q == CNT_LAST);
    assign last_addr = (addr_q == ADDR_LAST);

    // Next-state and handshake decisions; counters are steered via strobes.
    always_comb begin
        state_d  = state_q;
        rq_d     = rq_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        terr_d   = terr_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        addr_clr = 1'b0;
        addr_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d   = 1'b1;
                    terr_d   = 1'b0;
                    addr_clr = 1'b1;
                    cnt_clr  = 1'b1;
                    // A still-high ack holds the request off until it falls.
                    rq_d     = !ack_s;
                    state_d  = REQ;
                end
            end
            REQ: begin
                cnt_inc = 1'b1;
                if (rq_q && ack_s) begin
                    state_d = CAPT;
                end else if (cnt_hit) begin
                    data_d  = 8'h00;
                    terr_d  = 1'b1;
                    rq_d    = 1'b0;
                    valid_d = 1'b1;
                    state_d = PUSH;
                end else if (!rq_q && !ack_s) begin
                    // Stale ack has cleared; the ack-rise wait starts afresh.
                    rq_d    = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            CAPT: begin
                data_d  = data_in;
                rq_d    = 1'b0;
                cnt_clr = 1'b1;
                state_d = REL;
            end
            REL: begin
                cnt_inc = 1'b1;
                if (!ack_s) begin
                    valid_d = 1'b1;
                    state_d = PUSH;
                end else if (cnt_hit) begin
                    terr_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    done_d  = last_addr;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (last_addr) begin
                    addr_clr = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    addr_inc = 1'b1;
                    cnt_clr  = 1'b1;
                    rq_d     = !ack_s;
                    state_d  = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake timeout counter and byte address.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (addr_clr) begin
            addr_d = '0;
        end else if (addr_inc) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rq_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gating with rst drops the request as soon as reset is asserted,
    // without waiting for the next clock edge.
    assign rqRom       = rq_q & rst;
    assign LCSaddr     = addr_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_lcs_frame_reader.sv
// Bench for lcs_frame_reader: two instances (8-byte frame with short timeout,
// full 512-byte frame), a four-phase responder model and a stream scoreboard.
module tb_lcs_frame_reader;
    import lcs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       start [2];
    logic       rq [2];
    logic       ack [2];
    logic [8:0] addr [2];
    logic [7:0] din [2];
    logic [7:0] dout [2];
    logic       ovalid [2];
    logic       ready [2];
    logic       busy [2];
    logic       fd [2];
    logic       terr [2];

    int no_ack_addr [2] = '{-1, -1};
    bit temp_en [2]     = '{1'b0, 1'b0};
    bit stuck_ack [2]   = '{1'b0, 1'b0};
    bit rand_dly [2]    = '{1'b0, 1'b0};

    int n_xfer [2] = '{0, 0};
    int base [2]   = '{0, 0};
    int fd_cnt [2] = '{0, 0};
    int rq3 [2]    = '{0, 0};

    int n_chk = 0;
    int n_err = 0;

    lcs_frame_reader #(.FRAME_LEN(8), .ADDR_W(9), .TIMEOUT(16)) u_dut_short (
        .clk(clk), .rst(rst[0]), .start(start[0]), .rqRom(rq[0]), .ack(ack[0]),
        .LCSaddr(addr[0]), .data_in(din[0]), .out_data(dout[0]), .out_valid(ovalid[0]),
        .out_ready(ready[0]), .busy(busy[0]), .frame_done(fd[0]), .timeout_err(terr[0])
    );

    lcs_frame_reader #(.FRAME_LEN(512), .ADDR_W(9), .TIMEOUT(1023)) u_dut_full (
        .clk(clk), .rst(rst[1]), .start(start[1]), .rqRom(rq[1]), .ack(ack[1]),
        .LCSaddr(addr[1]), .data_in(din[1]), .out_data(dout[1]), .out_valid(ovalid[1]),
        .out_ready(ready[1]), .busy(busy[1]), .frame_done(fd[1]), .timeout_err(terr[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int g);
        return (g == 0) ? 8 : 512;
    endfunction

    // What the ROM side holds at an address.
    function automatic logic [7:0] resp_byte(input int g, input int a);
        if (temp_en[g] && is_temp_addr(a)) return 8'h11 + 8'(a - TEMP_ADDR_FIRST);
        return 8'(a) ^ 8'hA5;
    endfunction

    // What should appear at stream position pos: an unanswered byte reads as 0.
    function automatic logic [7:0] exp_byte(input int g, input int pos);
        if (pos == no_ack_addr[g]) return 8'h00;
        return resp_byte(g, pos);
    endfunction

    // Responder: acks after a delay, drops ack once the request falls.
    initial begin
        int wcnt [2];
        int tgt [2];
        for (int g = 0; g < 2; g++) begin
            ack[g] = 1'b0; din[g] = 8'h00; wcnt[g] = 0; tgt[g] = 2;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (stuck_ack[g]) begin
                    ack[g] = 1'b1; din[g] = 8'hEE; wcnt[g] = 0;
                end else if (!ack[g]) begin
                    if (rq[g] && int'(addr[g]) != no_ack_addr[g]) begin
                        wcnt[g]++;
                        if (wcnt[g] >= tgt[g]) begin
                            din[g] = resp_byte(g, int'(addr[g]));
                            ack[g] = 1'b1;
                            wcnt[g] = 0;
                            tgt[g] = rand_dly[g] ? int'($urandom_range(1, 4)) : 2;
                        end
                    end else begin
                        wcnt[g] = 0;
                    end
                end else if (!rq[g]) begin
                    ack[g] = 1'b0;
                end
            end
        end
    end

    // Stream scoreboard and frame_done pulse checks.
    initial begin
        bit prev_fd [2] = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst[g] && ovalid[g] && ready[g]) begin
                    check_eq($sformatf("byte%0d_%0d", g, n_xfer[g] - base[g]), 32'(dout[g]),
                             32'(exp_byte(g, n_xfer[g] - base[g])));
                    n_xfer[g]++;
                end
                if (rq[g] && addr[g] == 9'd3) rq3[g]++;
                if (fd[g]) begin
                    fd_cnt[g]++;
                    check_eq("busy_at_fd", 32'(busy[g]), 32'd1);
                end
                if (prev_fd[g]) begin
                    check_eq("fd_width", 32'(fd[g]), 32'd0);
                    check_eq("busy_after_fd", 32'(busy[g]), 32'd0);
                end
                prev_fd[g] = fd[g];
            end
        end
    end

    task automatic pulse_start(input int g);
        @(posedge clk); #1;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Run until frame_done (bounded); optionally fire start on the pulse itself.
    task automatic run_frame(input int g, input int budget, input bit rnd_ready, input bit start_on_fd);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (fd[g]) begin
                seen = 1'b1;
                if (start_on_fd) start[g] = 1'b1;
            end
            @(posedge clk); #1;
            start[g] = 1'b0;
            ready[g] = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        ready[g] = 1'b1;
        check_eq("frame_done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int f0;
        int r0;
        int bad;
        bit hit;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b0; start[g] = 1'b0; ready[g] = 1'b1;
        end

        // Reset then idle.
        wait_cycles(3);
        for (int g = 0; g < 2; g++) begin
            check_eq("rst_rqRom", 32'(rq[g]), 32'd0);
            check_eq("rst_addr", 32'(addr[g]), 32'd0);
            check_eq("rst_out_data", 32'(dout[g]), 32'd0);
            check_eq("rst_out_valid", 32'(ovalid[g]), 32'd0);
            check_eq("rst_busy", 32'(busy[g]), 32'd0);
            check_eq("rst_frame_done", 32'(fd[g]), 32'd0);
            check_eq("rst_timeout_err", 32'(terr[g]), 32'd0);
        end
        rst[0] = 1'b1; rst[1] = 1'b1;
        wait_cycles(6);
        check_eq("idle_rqRom", 32'(rq[0]), 32'd0);
        check_eq("idle_busy", 32'(busy[0]), 32'd0);

        // Full 8-byte frame, with an extra start mid-frame that must be ignored.
        base[0] = n_xfer[0]; f0 = fd_cnt[0];
        pulse_start(0);
        wait_cycles(10);
        pulse_start(0);
        run_frame(0, 400, 1'b0, 1'b0);
        check_eq("frame8_len", 32'(n_xfer[0] - base[0]), 32'(frame_len(0)));
        check_eq("frame8_fd_count", 32'(fd_cnt[0] - f0), 32'd1);
        check_eq("frame8_terr", 32'(terr[0]), 32'd0);

        // Backpressure on byte 0, then start coinciding with frame_done.
        ready[0] = 1'b0;
        base[0] = n_xfer[0];
        pulse_start(0);
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(posedge clk); #1;
            if (ovalid[0]) hit = 1'b1;
        end
        check_eq("bp_valid_seen", 32'(hit), 32'd1);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            check_eq("bp_valid_held", 32'(ovalid[0]), 32'd1);
            check_eq("bp_data_stable", 32'(dout[0]), 32'hA5);
            check_eq("bp_addr_hold", 32'(addr[0]), 32'd0);
            check_eq("bp_rq_low", 32'(rq[0]), 32'd0);
        end
        ready[0] = 1'b1;
        run_frame(0, 400, 1'b0, 1'b1);
        check_eq("bp_frame_len", 32'(n_xfer[0] - base[0]), 32'(frame_len(0)));
        wait_cycles(3);
        check_eq("start_at_fd_busy", 32'(busy[0]), 32'd0);
        check_eq("start_at_fd_rq", 32'(rq[0]), 32'd0);

        // Timeout at address 3.
        no_ack_addr[0] = 3;
        base[0] = n_xfer[0]; r0 = rq3[0];
        pulse_start(0);
        run_frame(0, 600, 1'b0, 1'b0);
        check_eq("to_frame_len", 32'(n_xfer[0] - base[0]), 32'(frame_len(0)));
        check_eq("to_err_set", 32'(terr[0]), 32'd1);
        check_eq("to_req_cycles", 32'(rq3[0] - r0), 32'd16);
        wait_cycles(2);
        no_ack_addr[0] = -1;
        base[0] = n_xfer[0];
        pulse_start(0);
        check_eq("to_err_cleared", 32'(terr[0]), 32'd0);
        run_frame(0, 400, 1'b0, 1'b0);
        check_eq("after_to_len", 32'(n_xfer[0] - base[0]), 32'(frame_len(0)));

        // Full frame with temperature bytes, random ack delay and backpressure.
        temp_en[1] = 1'b1; rand_dly[1] = 1'b1;
        base[1] = n_xfer[1];
        pulse_start(1);
        run_frame(1, 30000, 1'b1, 1'b0);
        check_eq("frame512_len", 32'(n_xfer[1] - base[1]), 32'(frame_len(1)));
        check_eq("frame512_terr", 32'(terr[1]), 32'd0);

        // Mid-frame reset.
        base[0] = n_xfer[0];
        pulse_start(0);
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(posedge clk); #1;
            if (addr[0] == 9'd4) hit = 1'b1;
        end
        check_eq("reach_addr4", 32'(hit), 32'd1);
        rst[0] = 1'b0;
        #1;
        check_eq("rst_rq_drop", 32'(rq[0]), 32'd0);
        @(posedge clk); #1;
        check_eq("mrst_busy", 32'(busy[0]), 32'd0);
        check_eq("mrst_addr", 32'(addr[0]), 32'd0);
        check_eq("mrst_valid", 32'(ovalid[0]), 32'd0);
        wait_cycles(2);
        rst[0] = 1'b1;

        // Start while ack is stuck high: no request until ack seen low.
        stuck_ack[0] = 1'b1;
        wait_cycles(4);
        base[0] = n_xfer[0];
        pulse_start(0);
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (rq[0] || ovalid[0]) bad++;
        end
        check_eq("stuck_no_req", 32'(bad), 32'd0);
        check_eq("stuck_busy", 32'(busy[0]), 32'd1);
        stuck_ack[0] = 1'b0;
        run_frame(0, 400, 1'b0, 1'b0);
        check_eq("stuck_frame_len", 32'(n_xfer[0] - base[0]), 32'(frame_len(0)));
        check_eq("stuck_terr", 32'(terr[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lcs_frame_reader.md
# lcs_frame_reader

Initiator side of the LCS ROM request/acknowledge link. On a frame trigger, it walks LCS byte addresses 0..FRAME_LEN-1 and raises a four-phase request for each one. It captures the byte returned by the responder on the other side of the link, including temperature bytes at addresses 184..187, and hands each byte to the downstream transmitter through a valid/ready stream. It sits between the frame timing logic and the serial output stage, in its own clock domain; `ack` is treated as asynchronous.

## Interface
Parameters:
- FRAME_LEN, 512, number of bytes per frame (2..512).
- ADDR_W, 9, width of LCSaddr.
- TIMEOUT, 1023, maximum cycles to wait for ack rise or ack fall before aborting that byte.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle frame trigger; ignored while busy.
- rqRom  out  1  request level to responder.
- ack  in  1  responder acknowledge; asynchronous, 2-FF synchronised internally.
- LCSaddr  out  ADDR_W  address of the current byte; stable from request rise until ack is seen low.
- data_in  in  8  responder data; guaranteed stable while ack is high.
- out_data  out  8  captured byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last byte is accepted.
- timeout_err  out  1  sticky; set on any timeout, cleared by an accepted start.

## Operation
- Reset values: rqRom=0, LCSaddr=0, out_data=0, out_valid=0, busy=0, frame_done=0, timeout_err=0, FSM=IDLE, sync flops=0, timeout counter=0.
- IDLE: on start=1, set busy=1, LCSaddr=0, timeout_err=0, then go to REQ.
- REQ: rqRom=1 and the timeout counter increments.
  - ack_s=1: go to CAPT.
  - Counter reaches TIMEOUT: out_data=8'h00, timeout_err=1, rqRom=0, go to PUSH.
- CAPT: out_data<=data_in, rqRom<=0, clear the counter, go to REL.
- REL: wait for ack_s=0, then go to PUSH.
  - If the counter reaches TIMEOUT first: timeout_err=1, go to PUSH with the captured byte.
- PUSH: out_valid=1, with out_data held constant until out_valid&&out_ready.
  - On transfer: out_valid=0, go to NEXT.
- NEXT:
  - If LCSaddr==FRAME_LEN-1: LCSaddr<=0, busy<=0, frame_done pulse, go to IDLE.
  - Otherwise: LCSaddr<=LCSaddr+1, go to REQ.
- A new request is never raised while ack_s=1. REQ entered with ack_s still high waits for ack_s low first; this is the stale-ack guard.
- Address arithmetic is ADDR_W-bit unsigned. Wrap is explicit at FRAME_LEN-1, never a natural overflow.
- start coinciding with frame_done: ignored, because busy is still 1 in that cycle.
- rst low mid-transaction: next edge applies the reset values; rqRom drops immediately. The responder recovers on its own through its RQ wait.

## Timing
- ack→ack_s latency: 2 clk. CAPT follows 1 clk after ack_s=1, so data_in is sampled 3 edges after the ack input rises.
- Minimum per-byte cost with out_ready=1 and an instant responder: REQ(1+2 sync)+CAPT(1)+REL(2 sync)+PUSH(1)+NEXT(1) ≈ 8 clk.
- out_valid rises the cycle after REL exits. Transfer occurs on the first edge where out_valid&&out_ready.
- frame_done is asserted for exactly 1 clk, in the cycle following the last transfer.

## Structure
- Shared package `lcs_pkg`:
  - FSM state enum {IDLE, REQ, CAPT, REL, PUSH, NEXT}.
  - LCS_ADDR_W=9.
  - Temperature window constants TEMP_ADDR_FIRST=184, TEMP_ADDR_LAST=187, used by the bench and the responder.
- Sub-module `sync2`: generic 2-flop synchroniser, used for ack.
- Everything else is one always block for the FSM and one for the counters.

## Test plan
- Reset then idle: rst=0 for 3 clk → all outputs at reset values; rqRom stays 0 with start=0.
- Full frame, FRAME_LEN=8, responder model returns addr^8'hA5 with 2-clk ack delay, out_ready=1 → bytes A5,A4,A7,A6,A1,A0,A3,A2 in order; one frame_done pulse; busy falls with it.
- Temperature window, FRAME_LEN=512, responder substitutes bytes 8'h11..8'h14 at addresses 184..187 → those four values appear at stream positions 184..187; the rest equal the ROM model.
- Backpressure: out_ready=0 for 10 clk during PUSH → out_valid held and out_data stable; rqRom stays 0; no address advance.
- Timeout: responder never acks at address 3, TIMEOUT=16 → byte 3 = 8'h00 after 16 REQ clk; timeout_err=1; frame completes; next start clears timeout_err.
- Mid-frame reset plus stuck-high ack at a new start → after reset the FSM is IDLE and LCSaddr=0; a start with ack held high produces no capture until ack has been seen low.
